aes_stream_enc: RTL

- Parametrised successor to the byte-serial AES top.
- Loads a key and 128-bit plaintext blocks over a ready/valid input bus IN_BYTES wide.
- Expands the key once into an internal round-key buffer. Encrypts each block iteratively, one AES round per cycle.
- Returns ciphertext on a ready/valid output. Key size (128/192/256) is fixed per instance by parameter. Encryption only.

---
 rtl/aes_stream_enc_if.sv | 25 ++
 rtl/aes_stream_enc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_enc_if.sv
// Ready/valid bundle between a key/plaintext producer and aes_stream_enc.
// The master drives beats and accepts ciphertext; the slave is the encryptor.
interface aes_stream_enc_if #(
   parameter int IN_BYTES = 1
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_key;
   logic [8*IN_BYTES-1:0] in_data;
   logic                  key_valid;
   logic                  out_valid;
   logic                  out_ready;
   logic [127:0]          out_data;
   logic                  err_nokey;

   modport master (
      output in_valid, in_key, in_data, out_ready,
      input  in_ready, key_valid, out_valid, out_data, err_nokey
   );

   modport slave (
      input  in_valid, in_key, in_data, out_ready,
      output in_ready, key_valid, out_valid, out_data, err_nokey
   );
endinterface

// File: rtl/aes_stream_enc.sv
// Streaming AES encryptor: key/plaintext packets over a ready/valid bus, key expanded
// once into a round-key buffer (one word/cycle), one AES round per cycle, ciphertext out.
module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign s_o = SBOX[a_i];
endmodule

module aes_stream_enc #(
   parameter int NK       = 4,
   parameter int IN_BYTES = 1
) (
   input  logic            clk,
   input  logic            reset,
   aes_stream_enc_if.slave bus
);
   localparam int         NR        = NK + 6;
   localparam int         NW        = 4 * (NR + 1);
   localparam int         IW        = 8 * IN_BYTES;
   localparam logic [5:0] KEY_LAST  = 6'(4 * NK / IN_BYTES);
   localparam logic [5:0] BLK_LAST  = 6'(16 / IN_BYTES);
   localparam logic [5:0] NK_L      = 6'(NK);
   localparam logic [5:0] W_LAST    = 6'(NW - 1);
   localparam logic [2:0] KMOD_LAST = 3'(NK - 1);
   localparam logic [3:0] NR_L      = 4'(NR);

   typedef enum logic [2:0] {IDLE, LOAD, KEXP, ROUND, OUT} st_e;

   st_e          st_q;
   logic [5:0]   cnt_q;
   logic         pkt_key_q;
   logic [255:0] key_sr_q;
   logic [127:0] blk_q;
   logic [127:0] state_q;
   logic [3:0]   rnd_q;
   logic [5:0]   wi_q;
   logic [2:0]   kmod_q;
   logic [7:0]   rcon_q;
   logic         in_ready_q;
   logic         key_valid_q;
   logic         out_valid_q;
   logic         err_q;
   logic [127:0] out_data_q;
   logic [31:0]  rk_q [NW];

   assign bus.in_ready  = in_ready_q;
   assign bus.key_valid = key_valid_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.err_nokey = err_q;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Beat acceptance and packet framing
   logic         acc, same_pkt, key_done, blk_done;
   logic [5:0]   cnt_d;
   logic [255:0] key_shift;
   logic [127:0] blk_shift;

   always_comb begin
      acc       = bus.in_valid & in_ready_q;
      same_pkt  = (cnt_q == 6'd0) || (bus.in_key == pkt_key_q);
      cnt_d     = same_pkt ? cnt_q + 6'd1 : 6'd1;
      key_shift = (key_sr_q << IW) | 256'(bus.in_data);
      blk_shift = (blk_q << IW) | 128'(bus.in_data);
      key_done  = acc & bus.in_key & (cnt_d == KEY_LAST);
      blk_done  = acc & ~bus.in_key & (cnt_d == BLK_LAST);
   end

   // Key expansion: one FIPS-197 word per cycle
   logic [31:0] w_prev, w_back, rot, sub_in, sub_out, temp, w_new;

   always_comb begin
      w_prev = rk_q[wi_q - 6'd1];
      w_back = rk_q[wi_q - NK_L];
      rot    = {w_prev[23:0], w_prev[31:24]};
      sub_in = (kmod_q == 3'd0) ? rot : w_prev;
      temp   = w_prev;
      if (kmod_q == 3'd0) begin
         temp = sub_out ^ {rcon_q, 24'h0};
      end else if (NK == 8 && kmod_q == 3'd4) begin
         temp = sub_out;
      end
      w_new = w_back ^ temp;
   end

   for (genvar g = 0; g < 4; g++) begin : g_subword
      aes_sbox u_sbox (.a_i(sub_in[31-8*g -: 8]), .s_o(sub_out[31-8*g -: 8]));
   end

   // Round datapath
   logic [127:0] sb, sr, mc, rk_r, rk0, rnd_out;
   logic [3:0]   rsel;
   logic [7:0]   a0, a1, a2, a3;

   for (genvar g = 0; g < 16; g++) begin : g_subbytes
      aes_sbox u_sbox (.a_i(state_q[127-8*g -: 8]), .s_o(sb[127-8*g -: 8]));
   end

   always_comb begin
      sr = '0;
      mc = '0;
      a0 = '0;
      a1 = '0;
      a2 = '0;
      a3 = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         a0 = sr[127-32*c -: 8];
         a1 = sr[119-32*c -: 8];
         a2 = sr[111-32*c -: 8];
         a3 = sr[103-32*c -: 8];
         mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      // rnd_q runs one past NR on the output cycle; clamp keeps the read in range
      rsel    = (rnd_q > NR_L) ? NR_L : rnd_q;
      rk_r    = {rk_q[{rsel, 2'd0}], rk_q[{rsel, 2'd1}], rk_q[{rsel, 2'd2}], rk_q[{rsel, 2'd3}]};
      rk0     = {rk_q[0], rk_q[1], rk_q[2], rk_q[3]};
      rnd_out = ((rnd_q == NR_L) ? sr : mc) ^ rk_r;
   end

   always_ff @(posedge clk) begin
      if (key_done) begin
         for (int k = 0; k < NK; k++) begin
            rk_q[k] <= key_shift[32*NK-1-32*k -: 32];
         end
      end else if (st_q == KEXP) begin
         rk_q[wi_q] <= w_new;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q        <= IDLE;
         cnt_q       <= '0;
         pkt_key_q   <= 1'b0;
         key_sr_q    <= '0;
         blk_q       <= '0;
         state_q     <= '0;
         rnd_q       <= '0;
         wi_q        <= NK_L;
         kmod_q      <= '0;
         rcon_q      <= 8'h01;
         in_ready_q  <= 1'b0;
         key_valid_q <= 1'b0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         out_data_q  <= '0;
      end else begin
         err_q <= 1'b0;
         case (st_q)
            IDLE, LOAD: begin
               in_ready_q <= 1'b1;
               if (acc) begin
                  pkt_key_q <= bus.in_key;
                  if (bus.in_key) key_sr_q <= key_shift;
                  else            blk_q    <= blk_shift;
                  if (key_done) begin
                     cnt_q       <= '0;
                     key_valid_q <= 1'b0;
                     in_ready_q  <= 1'b0;
                     wi_q        <= NK_L;
                     kmod_q      <= '0;
                     rcon_q      <= 8'h01;
                     st_q        <= KEXP;
                  end else if (blk_done) begin
                     cnt_q <= '0;
                     if (key_valid_q) begin
                        state_q    <= blk_shift ^ rk0;
                        rnd_q      <= 4'd1;
                        in_ready_q <= 1'b0;
                        st_q       <= ROUND;
                     end else begin
                        err_q <= 1'b1;
                        st_q  <= IDLE;
                     end
                  end else begin
                     cnt_q <= cnt_d;
                     st_q  <= LOAD;
                  end
               end
            end
            KEXP: begin
               kmod_q <= (kmod_q == KMOD_LAST) ? 3'd0 : kmod_q + 3'd1;
               if (kmod_q == 3'd0) rcon_q <= xt(rcon_q);
               if (wi_q == W_LAST) begin
                  key_valid_q <= 1'b1;
                  in_ready_q  <= 1'b1;
                  st_q        <= IDLE;
               end else begin
                  wi_q <= wi_q + 6'd1;
               end
            end
            ROUND: begin
               if (rnd_q <= NR_L) begin
                  state_q <= rnd_out;
                  rnd_q   <= rnd_q + 4'd1;
               end else begin
                  out_data_q  <= state_q;
                  out_valid_q <= 1'b1;
                  st_q        <= OUT;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  st_q        <= IDLE;
               end
            end
            default: st_q <= IDLE;
         endcase
      end
   end
endmodule
